// File: rtl/run_event_counter.sv
// rtl/run_event_counter.sv - zero/one run event statistics behind the four-in-a-row detector
// Classifies detector terminal states into zero/one runs and keeps saturating counts.
module run_event_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             res_n,
  input  logic             z,
  input  logic [3:0]       y,
  input  logic             clr,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] one_cnt,
  output logic [CNT_W-1:0] run_len,
  output logic [CNT_W-1:0] max_run,
  output logic             evt,
  output logic             ovf,
  output logic             err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_IN_ZERO = 2'd1;
  localparam logic [1:0] ST_IN_ONE  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // A detection already implies four identical input bits.
  localparam logic [CNT_W-1:0] RUN_START = CNT_W'(4);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
  logic [CNT_W-1:0] one_cnt_q, one_cnt_d;
  logic [CNT_W-1:0] run_len_q, run_len_d;
  logic [CNT_W-1:0] max_run_q, max_run_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             is_zero, is_one, is_bad;
  logic             new_evt, cont;
  logic [CNT_W-1:0] zero_base, one_base, run_base, max_base;

  always_comb begin
    is_zero = z && (y == 4'b0100);
    is_one  = z && (y == 4'b1000);
    is_bad  = z && !is_zero && !is_one;
    new_evt = (is_zero && (state_q != ST_IN_ZERO)) || (is_one && (state_q != ST_IN_ONE));
    cont    = (is_zero && (state_q == ST_IN_ZERO)) || (is_one && (state_q == ST_IN_ONE));

    // Clear first, then let this edge's event or continuation land on top of it.
    zero_base = clr ? '0 : zero_cnt_q;
    one_base  = clr ? '0 : one_cnt_q;
    run_base  = clr ? '0 : run_len_q;
    max_base  = clr ? '0 : max_run_q;

    state_d    = state_q;
    zero_cnt_d = zero_base;
    one_cnt_d  = one_base;
    run_len_d  = run_base;
    max_run_d  = max_base;
    evt_d      = 1'b0;
    ovf_d      = clr ? 1'b0 : ovf_q;
    err_d      = (clr ? 1'b0 : err_q) | is_bad;

    if (!z || is_bad) begin
      state_d = ST_IDLE;
    end else if (is_zero) begin
      state_d = ST_IN_ZERO;
    end else begin
      state_d = ST_IN_ONE;
    end

    if (new_evt) begin
      evt_d     = 1'b1;
      run_len_d = RUN_START;
      if (is_zero) begin
        if (zero_base == CNT_MAX) ovf_d = 1'b1;
        else                      zero_cnt_d = zero_base + CNT_ONE;
      end else begin
        if (one_base == CNT_MAX) ovf_d = 1'b1;
        else                     one_cnt_d = one_base + CNT_ONE;
      end
    end

    if (cont) begin
      if (run_base == CNT_MAX) ovf_d = 1'b1;
      else                     run_len_d = run_base + CNT_ONE;
    end

    if (new_evt || cont) begin
      max_run_d = (run_len_d > max_base) ? run_len_d : max_base;
    end
  end

  always_ff @(posedge CLK or negedge res_n) begin
    if (!res_n) begin
      state_q    <= ST_IDLE;
      zero_cnt_q <= '0;
      one_cnt_q  <= '0;
      run_len_q  <= '0;
      max_run_q  <= '0;
      evt_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      zero_cnt_q <= zero_cnt_d;
      one_cnt_q  <= one_cnt_d;
      run_len_q  <= run_len_d;
      max_run_q  <= max_run_d;
      evt_q      <= evt_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
  assign one_cnt  = one_cnt_q;
  assign run_len  = run_len_q;
  assign max_run  = max_run_q;
  assign evt      = evt_q;
  assign ovf      = ovf_q;
  assign err      = err_q;

endmodule

// File: tb/tb_run_event_counter.sv
// tb/tb_run_event_counter.sv - scoreboard bench for run_event_counter at CNT_W=8 and CNT_W=3
module tb_run_event_counter;

  logic       CLK = 1'b0;
  logic       res_n, z, clr;
  logic [3:0] y;

  logic [7:0] a_zc, a_oc, a_rl, a_mr;
  logic       a_evt, a_ovf, a_err;
  logic [2:0] b_zc, b_oc, b_rl, b_mr;
  logic       b_evt, b_ovf, b_err;

  always #5 CLK = ~CLK;

  run_event_counter #(.CNT_W(8)) u_w8 (
    .CLK(CLK), .res_n(res_n), .z(z), .y(y), .clr(clr),
    .zero_cnt(a_zc), .one_cnt(a_oc), .run_len(a_rl), .max_run(a_mr),
    .evt(a_evt), .ovf(a_ovf), .err(a_err)
  );

  run_event_counter #(.CNT_W(3)) u_w3 (
    .CLK(CLK), .res_n(res_n), .z(z), .y(y), .clr(clr),
    .zero_cnt(b_zc), .one_cnt(b_oc), .run_len(b_rl), .max_run(b_mr),
    .evt(b_evt), .ovf(b_ovf), .err(b_err)
  );

  typedef struct {
    int zc, oc, rl, mr;
    bit evt, ovf, err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int n_checks = 0;
  int n_pass   = 0;
  int evt_seen = 0;

  int m_st[2], m_zc[2], m_oc[2], m_rl[2], m_mr[2];
  bit m_evt[2], m_ovf[2], m_err[2];
  int m_max[2] = '{255, 7};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int inc(input int k, input int v);
    if (v >= m_max[k]) begin
      m_ovf[k] = 1'b1;
      return v;
    end
    return v + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_zc[k] = 0; m_oc[k] = 0; m_rl[k] = 0; m_mr[k] = 0;
      m_evt[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
    end
  endtask

  // State encoding inside the model: 0 idle, 1 in zero run, 2 in one run.
  task automatic model_step(input int k, input bit zi, input logic [3:0] yi, input bit ci);
    if (ci) begin
      m_zc[k] = 0; m_oc[k] = 0; m_rl[k] = 0; m_mr[k] = 0; m_ovf[k] = 0; m_err[k] = 0;
    end
    m_evt[k] = 0;
    if (!zi) begin
      m_st[k] = 0;
    end else if (yi == 4'b0100 || yi == 4'b1000) begin
      int want;
      want = (yi == 4'b0100) ? 1 : 2;
      if (m_st[k] != want) begin
        if (want == 1) m_zc[k] = inc(k, m_zc[k]);
        else           m_oc[k] = inc(k, m_oc[k]);
        m_rl[k]  = 4;
        m_evt[k] = 1;
      end else begin
        m_rl[k] = inc(k, m_rl[k]);
      end
      m_st[k] = want;
      if (m_rl[k] > m_mr[k]) m_mr[k] = m_rl[k];
    end else begin
      m_st[k]  = 0;
      m_err[k] = 1;
    end
  endtask

  function automatic exp_t snap(input int k);
    exp_t e;
    e.zc = m_zc[k]; e.oc = m_oc[k]; e.rl = m_rl[k]; e.mr = m_mr[k];
    e.evt = m_evt[k]; e.ovf = m_ovf[k]; e.err = m_err[k];
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    check("sb_a_nonempty", int'(q_a.size() > 0), 1);
    check("sb_b_nonempty", int'(q_b.size() > 0), 1);
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("w8 zero_cnt", int'(a_zc), e.zc);
      check("w8 one_cnt",  int'(a_oc), e.oc);
      check("w8 run_len",  int'(a_rl), e.rl);
      check("w8 max_run",  int'(a_mr), e.mr);
      check("w8 evt",      int'(a_evt), int'(e.evt));
      check("w8 ovf",      int'(a_ovf), int'(e.ovf));
      check("w8 err",      int'(a_err), int'(e.err));
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("w3 zero_cnt", int'(b_zc), e.zc);
      check("w3 one_cnt",  int'(b_oc), e.oc);
      check("w3 run_len",  int'(b_rl), e.rl);
      check("w3 max_run",  int'(b_mr), e.mr);
      check("w3 evt",      int'(b_evt), int'(e.evt));
      check("w3 ovf",      int'(b_ovf), int'(e.ovf));
      check("w3 err",      int'(b_err), int'(e.err));
    end
  endtask

  task automatic cyc(input bit zi, input logic [3:0] yi, input bit ci);
    @(negedge CLK);
    z = zi; y = yi; clr = ci;
    model_step(0, zi, yi, ci);
    model_step(1, zi, yi, ci);
    q_a.push_back(snap(0));
    q_b.push_back(snap(1));
    @(posedge CLK);
    #1;
    compare_out();
    evt_seen += int'(a_evt);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " w8 outs"}, int'({a_zc, a_oc, a_rl, a_mr, a_evt, a_ovf, a_err}), 0);
    check({tag, " w3 outs"}, int'({b_zc, b_oc, b_rl, b_mr, b_evt, b_ovf, b_err}), 0);
  endtask

  // Drops reset in the middle of the low clock phase; inputs are left as they are.
  task automatic do_reset(input string tag);
    @(negedge CLK);
    #2 res_n = 1'b0;
    #1 check_all_zero({tag, " async"});
    model_reset();
    @(posedge CLK);
    #1 check_all_zero({tag, " held"});
    #2 res_n = 1'b1;
  endtask

  initial begin
    res_n = 1'b0; z = 1'b0; y = 4'b0000; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 check_all_zero("reset");
    #2 res_n = 1'b1;

    // Three-cycle zero run.
    repeat (3) cyc(1, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    check("tp1 zero_cnt", int'(a_zc), 1);
    check("tp1 run_len", int'(a_rl), 6);
    check("tp1 max_run", int'(a_mr), 6);
    check("tp1 one_cnt", int'(a_oc), 0);

    // Zero, idle, four ones, zero directly after.
    do_reset("tp2");
    evt_seen = 0;
    cyc(1, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    repeat (4) cyc(1, 4'b1000, 0);
    cyc(1, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    check("tp2 zero_cnt", int'(a_zc), 2);
    check("tp2 one_cnt", int'(a_oc), 1);
    check("tp2 max_run", int'(a_mr), 7);
    check("tp2 run_len", int'(a_rl), 4);
    check("tp2 evt pulses", evt_seen, 3);

    // Six-cycle zero run saturates the narrow instance.
    do_reset("tp3");
    repeat (6) cyc(1, 4'b0100, 0);
    cyc(0, 4'b0000, 0);
    check("tp3 w3 run_len", int'(b_rl), 7);
    check("tp3 w3 ovf", int'(b_ovf), 1);
    check("tp3 w3 max_run", int'(b_mr), 7);
    check("tp3 w8 run_len", int'(a_rl), 9);
    check("tp3 w8 ovf", int'(a_ovf), 0);

    // Illegal state code, then a fresh zero event.
    cyc(1, 4'b0011, 0);
    check("tp4 err", int'(a_err), 1);
    check("tp4 evt", int'(a_evt), 0);
    check("tp4 zero_cnt", int'(a_zc), 1);
    cyc(1, 4'b0100, 0);
    check("tp4 new evt", int'(a_evt), 1);
    check("tp4 zero_cnt2", int'(a_zc), 2);

    // Build one_cnt=5 with err and narrow ovf set, then clear on a new one event.
    do_reset("tp5");
    repeat (5) cyc(1, 4'b1000, 0);
    cyc(0, 4'b0000, 0);
    repeat (4) begin
      cyc(1, 4'b1000, 0);
      cyc(0, 4'b0000, 0);
    end
    cyc(1, 4'b1111, 0);
    cyc(0, 4'b0000, 0);
    check("tp5 pre one_cnt", int'(a_oc), 5);
    check("tp5 pre err", int'(a_err), 1);
    check("tp5 pre w3 ovf", int'(b_ovf), 1);
    cyc(1, 4'b1000, 1);
    check("tp5 one_cnt", int'(a_oc), 1);
    check("tp5 run_len", int'(a_rl), 4);
    check("tp5 max_run", int'(a_mr), 4);
    check("tp5 err", int'(a_err), 0);
    check("tp5 w3 ovf", int'(b_ovf), 0);
    check("tp5 evt", int'(a_evt), 1);
    cyc(1, 4'b1000, 1);
    check("tp5 cont run_len", int'(a_rl), 1);
    check("tp5 cont max_run", int'(a_mr), 1);

    // Reset mid-run with a one sample still held.
    cyc(1, 4'b1000, 0);
    do_reset("tp6");
    cyc(1, 4'b1000, 0);
    check("tp6 evt", int'(a_evt), 1);
    check("tp6 one_cnt", int'(a_oc), 1);
    check("tp6 run_len", int'(a_rl), 4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      logic [3:0] yr;
      case ($urandom_range(0, 3))
        0, 1:    yr = 4'b0100;
        2:       yr = 4'b1000;
        default: yr = 4'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, yr, $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/run_event_counter.md
# run_event_counter

Downstream statistics stage for the four-in-a-row sequence detector. Consumes the detector's `z` flag and 4-bit state code `y`, classifies each detection as a run of zeros (`y` = 4'b0100) or a run of ones (`y` = 4'b1000), and counts events of each kind. It also tracks the current run length and the longest run seen. All outputs are registered and drive LEDs/HEX decoders on the board.

## Interface
- `CNT_W`, default 8: width of the event counters and run-length registers.
- `CLK`  input  1  system clock; all state changes on the rising edge.
- `res_n`  input  1  reset, asynchronous, active-low.
- `z`  input  1  detector output; high while the detector is in a terminal state.
- `y`  input  4  detector state code; only 4'b0100 and 4'b1000 are meaningful while `z`=1.
- `clr`  input  1  synchronous clear of statistics, active-high.
- `zero_cnt`  output  CNT_W  number of zero-run events.
- `one_cnt`  output  CNT_W  number of one-run events.
- `run_len`  output  CNT_W  length in input bits of the current or most recent run.
- `max_run`  output  CNT_W  largest `run_len` value since reset/clear.
- `evt`  output  1  one-cycle pulse on each new event.
- `ovf`  output  1  sticky; set when any counter/length saturates.
- `err`  output  1  sticky; set when `z`=1 with an illegal `y`.

## Operation
- Reset (`res_n`=0, asynchronous): FSM to IDLE; all outputs 0.
- FSM states: IDLE, IN_ZERO, IN_ONE. Class of a sample: ZERO if `z`=1 and `y`=4'b0100; ONE if `z`=1 and `y`=4'b1000; BAD if `z`=1 and any other `y`; NONE if `z`=0.
- Transitions on each edge:
  - NONE -> IDLE from any state.
  - BAD -> IDLE, set `err`.
  - ZERO from IDLE or IN_ONE -> IN_ZERO as a new event: `zero_cnt`+1, `run_len`=4, `evt`=1.
  - ZERO in IN_ZERO -> stay as a continuation: `run_len`+1.
  - ONE is symmetric, using IN_ONE and `one_cnt`.
- `run_len` holds its value in IDLE until the next event.
- `max_run` is updated on the same edge as `run_len`: `max_run` = max(`max_run`, new `run_len`).
- Saturation: counters and `run_len` stop at 2^CNT_W-1. A saturated increment sets `ovf`. No wrap-around.
- `clr`=1:
  - `zero_cnt`, `one_cnt`, `run_len`, `max_run`, `ovf`, `err` cleared.
  - FSM state unchanged.
  - An event or continuation on the same edge is applied after the clear. Example: new ZERO event gives `zero_cnt`=1, `run_len`=4, `max_run`=4. Continuation gives `run_len`=1, `max_run`=1.
  - `evt` is unaffected by `clr`.
- `err` and `ovf` clear only on reset or `clr`.

## Timing
- Inputs are sampled on the rising `CLK` edge; outputs update on that same edge (one-cycle latency from input to output).
- `evt` is high exactly one cycle per event. Back-to-back events (ZERO then ONE on consecutive cycles) give two consecutive `evt` pulses.
- Asynchronous reset mid-run clears all outputs immediately. The first sample after release is treated from IDLE.
- `z`/`y` must be synchronous to `CLK`; no internal synchronizer.

## Test plan
- Reset, then drive `z`=1, `y`=4'b0100 for 3 cycles, then `z`=0 -> `evt` high only on the first edge; `zero_cnt`=1, `run_len`=6, `max_run`=6, `one_cnt`=0.
- ZERO run of 1 cycle, 1 idle cycle, ONE run of 4 cycles, then ZERO for 1 cycle (no idle between) -> `zero_cnt`=2, `one_cnt`=1, `max_run`=7, `run_len`=4, three `evt` pulses.
- `CNT_W`=3; ZERO run of 6 cycles -> `run_len` saturates at 7, `ovf`=1; `max_run`=7.
- `z`=1 with `y`=4'b0011 -> `err`=1, state IDLE, no `evt`, counts unchanged. Next ZERO sample counts as a new event.
- `clr` asserted on the edge of a new ONE event, with `one_cnt`=5 -> `one_cnt`=1, `run_len`=4, `max_run`=4, `err`/`ovf` cleared, `evt`=1.
- `res_n` dropped between clock edges mid-run -> all outputs 0 before the next `CLK` edge. After release, `z`=1/ONE still held -> counted as a new event.
